tlu_coinc_trig: RTL
===================

Name: tlu_coinc_trig

Overview:
- Sits directly downstream of the per-channel TLU input receivers.
- Combines the per-channel VALID flags into a masked coincidence. On each new coincidence it issues a trigger pulse and runs a DUT-busy / hold-off sequencer.
- Captures a trigger record: trigger number, timestamp and per-channel leading-edge times. The record is presented on a valid/ready interface to the readout FIFO.

Parameters:
- CH, 6, number of receiver channels
- TRIG_LEN, 4, TRIGGER pulse width in CLK40 cycles (>=1)
- BUSY_TIMEOUT, 1024, max cycles spent in WAIT_BUSY before timeout (>=1)

Ports:
- CLK40  in  1  system clock
- RST  in  1  synchronous, active-high reset
- EN  in  1  trigger generation enable
- EN_CH_MASK  in  CH  channels required in coincidence
- CH_VALID  in  CH  per-channel valid-hit flags from receivers
- CH_LE_REL  in  CH*16  per-channel leading-edge age; channel k at [16k+15:16k], units of 1/16 CLK40
- TIME_STAMP  in  32  free-running timestamp
- HOLDOFF  in  8  dead cycles after busy release
- DUT_BUSY  in  1  OR of DUT busy lines, already synchronised
- TRIGGER  out  1  trigger pulse to DUTs
- BUSY  out  1  high whenever FSM not IDLE
- TRIG_CNT  out  32  accepted trigger count
- SKIP_CNT  out  16  rejected coincidence count, saturating
- TIMEOUT_ERR  out  1  sticky busy-timeout flag
- REC_DATA  out  64+CH*8  trigger record
- REC_VALID  out  1  record valid
- REC_READY  in  1  consumer ready

Behaviour:
Reset values:
- All outputs 0; FSM in IDLE; COINC_PREV 0.

Coincidence detection:
- COINC = EN & (EN_CH_MASK != 0) & ((CH_VALID & EN_CH_MASK) == EN_CH_MASK).
- COINC_PREV is COINC registered each cycle.
- NEW = COINC & ~COINC_PREV. Only the rising edge counts; a VALID held high for many cycles yields one event.

Accept and skip:
- ACCEPT = NEW & (state == IDLE) & ~(REC_VALID & ~REC_READY).
- NEW & ~ACCEPT: SKIP_CNT += 1, saturating at 16'hFFFF.

On ACCEPT at edge n:
- Record latched from cycle-n inputs:
  - REC_DATA[31:0] = TIME_STAMP
  - REC_DATA[63:32] = TRIG_CNT before increment, so the first record number is 0
  - Byte for channel k at [64+8k+7:64+8k] = (rel >= 256) ? 8'hFF : rel[7:0] when mask bit k is set, else 8'h00
- REC_VALID = 1 from cycle n+1.
- TRIG_CNT increments, wrapping at 2^32.

Record handshake:
- Transfer when REC_VALID & REC_READY; REC_VALID then clears, unless an ACCEPT occurs in the same cycle, which reloads the record and keeps REC_VALID high.
- REC_DATA is stable while REC_VALID & ~REC_READY.

FSM:
- IDLE: ACCEPT -> TRIG.
- TRIG:
  - TRIGGER = 1 for exactly TRIG_LEN cycles, cycles n+1 .. n+TRIG_LEN.
  - Then -> WAIT_BUSY.
- WAIT_BUSY:
  - DUT_BUSY == 0 -> HOLDOFF (or IDLE if HOLDOFF == 0).
  - Cycle counter reaching BUSY_TIMEOUT -> TIMEOUT_ERR = 1, then -> HOLDOFF (or IDLE if HOLDOFF == 0).
  - A DUT_BUSY that rises during TRIG is honoured here.
- HOLDOFF: counts HOLDOFF cycles, sampled on entry, then -> IDLE.

BUSY:
- BUSY = (state != IDLE), registered, aligned with the state.

Disable and reset mid-operation:
- EN low in any state forces IDLE next cycle and TRIGGER deasserts; the pending record and all counters are kept.
- RST mid-operation clears everything, including the pending record; TIMEOUT_ERR clears only by RST.

Minimum trigger spacing:
- 1 + TRIG_LEN + busy time + HOLDOFF cycles.

Test Plan:
- Coincidence: mask=6'b000011; CH_VALID 0 -> 6'b000011 at cycle n with ch0 rel=40, ch1 rel=300, TIME_STAMP=0x100 -> TRIGGER high cycles n+1..n+4; REC_VALID at n+1 with time=0x100, number=0, bytes 0x28, 0xFF, others 0x00; TRIG_CNT=1.
- Partial / held VALID: mask=6'b000111, only ch0/ch1 valid -> no trigger. All three valid held 20 cycles, DUT_BUSY=0, HOLDOFF=0 -> exactly one trigger; SKIP_CNT=0.
- Backpressure: REC_READY=0, two coincidences separated by 50 cycles -> second coincidence skipped, SKIP_CNT=1, TRIG_CNT=1, first record unchanged. Raise REC_READY -> REC_VALID drops next cycle.
- Busy / hold-off: DUT_BUSY rises at n+2 and falls at n+30, HOLDOFF=10 -> BUSY high from n+1 to n+40 inclusive; a coincidence at n+35 is skipped. With DUT_BUSY stuck high, TIMEOUT_ERR sets after 1024 WAIT_BUSY cycles and the FSM returns to IDLE.
- Disable mid-trigger: EN low during TRIG -> TRIGGER low next cycle, FSM IDLE, record kept. RST during WAIT_BUSY -> all outputs 0, including REC_VALID and TIMEOUT_ERR.
- Counter limits: 65540 skipped coincidences -> SKIP_CNT = 0xFFFF. TRIG_CNT preset near wrap by forced accepts -> 0xFFFFFFFF followed by 0, record number carries the pre-increment value.

Source files
------------

// File: rtl/tlu_coinc_trig_if.sv
// Trigger-record port between the coincidence trigger (master) and the readout FIFO (slave).
// REC_DATA is {per-channel LE bytes, trigger number[31:0], timestamp[31:0]}.
interface tlu_coinc_trig_if #(
    parameter int CH = 6
);
    logic [64+CH*8-1:0] REC_DATA;
    logic               REC_VALID;
    logic               REC_READY;

    modport master (output REC_DATA, output REC_VALID, input REC_READY);
    modport slave  (input REC_DATA, input REC_VALID, output REC_READY);
endinterface

// File: rtl/tlu_coinc_trig.sv
// Masked coincidence trigger: TRIGGER and BUSY follow an accept by one cycle, the record is valid one cycle after accept.
// A record held by REC_READY low blocks further accepts; such coincidences are counted as skipped.
module tlu_coinc_trig #(
    parameter int CH           = 6,
    parameter int TRIG_LEN     = 4,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic               CLK40,
    input  logic               RST,
    input  logic               EN,
    input  logic [CH-1:0]      EN_CH_MASK,
    input  logic [CH-1:0]      CH_VALID,
    input  logic [CH*16-1:0]   CH_LE_REL,
    input  logic [31:0]        TIME_STAMP,
    input  logic [7:0]         HOLDOFF,
    input  logic               DUT_BUSY,
    output logic               TRIGGER,
    output logic               BUSY,
    output logic [31:0]        TRIG_CNT,
    output logic [15:0]        SKIP_CNT,
    output logic               TIMEOUT_ERR,
    tlu_coinc_trig_if.master   rec
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TRIG = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam int TL_W = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
    localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TL_W-1:0] TL_LAST = TL_W'(TRIG_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
    localparam int RW = 64 + CH*8;

    logic [1:0]      state_q, state_nxt;
    logic [TL_W-1:0] tl_cnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [7:0]      hold_cnt_q;
    logic            coinc, coinc_prev_q, new_evt, accept, rec_stall;
    logic            busy_done, timeout_hit;
    logic            trigger_q, busy_q, timeout_q;
    logic [31:0]     trig_cnt_q;
    logic [15:0]     skip_cnt_q, skip_nxt;
    logic            rec_vld_q;
    logic [RW-1:0]   rec_dat_q, rec_nxt;

    assign coinc     = EN && (EN_CH_MASK != '0) && ((CH_VALID & EN_CH_MASK) == EN_CH_MASK);
    assign new_evt   = coinc && !coinc_prev_q;
    assign rec_stall = rec_vld_q && !rec.REC_READY;
    assign accept    = new_evt && (state_q == S_IDLE) && !rec_stall;

    // A busy line still high on the last allowed wait cycle ends the wait as a timeout.
    assign busy_done   = (state_q == S_WAIT) && (!DUT_BUSY || (to_cnt_q == TO_LAST));
    assign timeout_hit = (state_q == S_WAIT) && EN && DUT_BUSY && (to_cnt_q == TO_LAST);

    always_comb begin
        skip_nxt = skip_cnt_q;
        if (new_evt && !accept && (skip_cnt_q != 16'hFFFF))
            skip_nxt = skip_cnt_q + 16'd1;
    end

    always_comb begin
        rec_nxt        = '0;
        rec_nxt[31:0]  = TIME_STAMP;
        rec_nxt[63:32] = trig_cnt_q;
        for (int k = 0; k < CH; k++) begin
            if (EN_CH_MASK[k])
                rec_nxt[64+8*k +: 8] = (|CH_LE_REL[16*k+8 +: 8]) ? 8'hFF : CH_LE_REL[16*k +: 8];
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (accept) state_nxt = S_TRIG;
            S_TRIG: if (tl_cnt_q == TL_LAST) state_nxt = S_WAIT;
            S_WAIT: if (busy_done) state_nxt = (HOLDOFF == 8'd0) ? S_IDLE : S_HOLD;
            S_HOLD: if (hold_cnt_q == 8'd0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (!EN)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK40) begin
        if (RST) begin
            state_q      <= S_IDLE;
            trigger_q    <= 1'b0;
            busy_q       <= 1'b0;
            coinc_prev_q <= 1'b0;
            tl_cnt_q     <= '0;
            to_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            trig_cnt_q   <= '0;
            skip_cnt_q   <= '0;
            rec_vld_q    <= 1'b0;
            rec_dat_q    <= '0;
        end else begin
            state_q      <= state_nxt;
            trigger_q    <= (state_nxt == S_TRIG);
            busy_q       <= (state_nxt != S_IDLE);
            coinc_prev_q <= coinc;
            tl_cnt_q     <= (state_q == S_TRIG) ? tl_cnt_q + TL_W'(1) : '0;
            to_cnt_q     <= (state_q == S_WAIT) ? to_cnt_q + TO_W'(1) : '0;
            // HOLDOFF is captured on the edge that enters the hold-off phase.
            hold_cnt_q   <= (state_q == S_HOLD) ? hold_cnt_q - 8'd1 : HOLDOFF - 8'd1;
            if (timeout_hit)
                timeout_q <= 1'b1;
            trig_cnt_q   <= trig_cnt_q + {31'd0, accept};
            skip_cnt_q   <= skip_nxt;
            if (accept) begin
                rec_vld_q <= 1'b1;
                rec_dat_q <= rec_nxt;
            end else if (rec.REC_READY) begin
                rec_vld_q <= 1'b0;
            end
        end
    end

    assign TRIGGER       = trigger_q;
    assign BUSY          = busy_q;
    assign TRIG_CNT      = trig_cnt_q;
    assign SKIP_CNT      = skip_cnt_q;
    assign TIMEOUT_ERR   = timeout_q;
    assign rec.REC_VALID = rec_vld_q;
    assign rec.REC_DATA  = rec_dat_q;
endmodule
